// File: rtl/vga_timing_defs.sv
// Shared VGA timing constants and colour types, used by the scan driver and by
// the on-screen renderers for their screen-extent checks.
package vga_timing_defs;

    localparam int COORD_W = 10;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int RED_W = 3;
    localparam int GRN_W = 3;
    localparam int BLU_W = 2;

    typedef struct packed {
        logic [RED_W-1:0] r;
        logic [GRN_W-1:0] g;
        logic [BLU_W-1:0] b;
    } rgb_t;

    // True when lo <= pos < hi.
    function automatic logic in_window(input logic [COORD_W-1:0] pos,
                                       input int lo, input int hi);
        return (32'(pos) >= 32'(lo)) && (32'(pos) < 32'(hi));
    endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate strobe: one-clk pulse every CLK_DIV clocks, first pulse CLK_DIV
// clocks after reset release (CLK_DIV=1 gives a constant strobe).
module pix_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // The strobe is registered from the next count so it reads 0 during reset
    // yet is high exactly while the count sits at CLK_DIV-1.
    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        tick_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/vga_scan_driver.sv
// VGA raster timing generator: drives the shared hc/vc bus, then blanks,
// registers and aligns the returned renderer colour with hsync/vsync.
module vga_scan_driver
    import vga_timing_defs::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [COORD_W-1:0] hc,
    output logic [COORD_W-1:0] vc,
    output logic               pix_en,
    output logic               video_on,
    output logic               frame_tick,
    input  logic [RED_W-1:0]   red_in,
    input  logic [GRN_W-1:0]   green_in,
    input  logic [BLU_W-1:0]   blue_in,
    output logic [RED_W-1:0]   vga_r,
    output logic [GRN_W-1:0]   vga_g,
    output logic [BLU_W-1:0]   vga_b,
    output logic               vga_hs,
    output logic               vga_vs
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS   = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS   = COORD_W'(V_ACTIVE);

    logic               tick;
    logic [COORD_W-1:0] hc_q, hc_d;
    logic [COORD_W-1:0] vc_q, vc_d;
    rgb_t               rgb_q, rgb_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               ftick_q, ftick_d;
    logic               line_end;
    logic               frame_end;
    logic               active;

    pix_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign line_end  = (hc_q == H_LAST);
    assign frame_end = line_end && (vc_q == V_LAST);
    assign active    = (hc_q < H_VIS) && (vc_q < V_VIS);

    // Everything below is decoded from the pre-increment position, so colour
    // and sync leave the block together, one pixel behind hc/vc.
    always_comb begin
        hc_d    = hc_q;
        vc_d    = vc_q;
        rgb_d   = rgb_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        ftick_d = tick && frame_end;
        if (tick) begin
            hc_d = line_end ? '0 : hc_q + COORD_W'(1);
            if (line_end) begin
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + COORD_W'(1);
            end
            rgb_d = active ? rgb_t'({red_in, green_in, blue_in}) : rgb_t'('0);
            hs_d  = in_window(hc_q, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
            vs_d  = in_window(vc_q, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q    <= '0;
            vc_q    <= '0;
            rgb_q   <= '0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            ftick_q <= 1'b0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            ftick_q <= ftick_d;
        end
    end

    assign hc         = hc_q;
    assign vc         = vc_q;
    assign pix_en     = tick;
    assign video_on   = active;
    assign frame_tick = ftick_q;
    assign vga_r      = rgb_q.r;
    assign vga_g      = rgb_q.g;
    assign vga_b      = rgb_q.b;
    assign vga_hs     = hs_q;
    assign vga_vs     = vs_q;

endmodule
